mem_port_arbiter: RTL and testbench

//  Shares one single-ported 64-bit data RAM between the core's instruction-fetch requester (IF) and load/store requester (LS).

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_grant.sv | 36 +++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
package mem_arb_pkg;

  // Which requester owns the RAM response returning in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS_RD,
    OWN_LS_WR
  } owner_e;

  localparam logic [7:0] BE_ALL = 8'hFF;

  // Select one instruction from a RAM word using byte-address bit 2.
  function automatic logic [31:0] pick_inst(input logic [63:0] word, input logic lane);
    return lane ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between IF and LS with an LS streak limit protecting fetch.
module mem_arb_grant #(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_valid,
  input  logic       ls_valid,
  output logic       if_grant,
  output logic       ls_grant,
  output logic [3:0] ls_streak
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  logic streak_full;

  // LS wins contention until it has held the port STREAK_MAX times in a row.
  always_comb begin
    streak_full = (ls_streak == STREAK_MAX);
    ls_grant    = ls_valid && !(if_valid && streak_full);
    if_grant    = if_valid && !ls_grant;
  end

  // Count LS grants taken while IF waits; any IF grant or idle IF clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_streak <= '0;
    end else if (!if_valid || if_grant) begin
      ls_streak <= '0;
    end else if (ls_grant && !streak_full) begin
      ls_streak <= ls_streak + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 64-bit RAM between instruction fetch and load/store.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 13,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned INST_W        = 32,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [INST_W-1:0] if_rsp_inst,
  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [7:0]        ls_req_be,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-4:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic       if_grant;
  logic       ls_grant;
  logic [3:0] ls_streak;
  owner_e     owner;
  logic       lane;
  logic       unused_bits;

  // Low address bits below the access granularity are ignored by design.
  assign unused_bits = ^{if_req_addr[1:0], ls_req_addr[2:0], ls_streak};

  // Reset gates the valids so ready and mem_* read as 0 while rst_n is low.
  mem_arb_grant #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_grant (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_req_valid && rst_n),
    .ls_valid (ls_req_valid && rst_n),
    .if_grant (if_grant),
    .ls_grant (ls_grant),
    .ls_streak(ls_streak)
  );

  assign if_req_ready = if_grant;
  assign ls_req_ready = ls_grant;

  // Drive the RAM straight from whichever request is granted this cycle.
  always_comb begin
    mem_en    = if_grant || ls_grant;
    mem_we    = ls_grant && ls_req_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (ls_grant) begin
      mem_addr  = ls_req_addr[ADDR_W-1:3];
      mem_be    = ls_req_we ? ls_req_be : BE_ALL;
      mem_wdata = ls_req_we ? ls_req_wdata : '0;
    end else if (if_grant) begin
      mem_addr = if_req_addr[ADDR_W-1:3];
      mem_be   = BE_ALL;
    end
  end

  // Remember who owns next cycle's response and which instruction lane it wants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_NONE;
      lane  <= 1'b0;
    end else begin
      lane <= if_grant ? if_req_addr[2] : 1'b0;
      if (ls_grant) begin
        owner <= ls_req_we ? OWN_LS_WR : OWN_LS_RD;
      end else if (if_grant) begin
        owner <= OWN_IF;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  // Steer returning RAM data to its owner; data is forced to 0 when not valid.
  always_comb begin
    if_rsp_valid = (owner == OWN_IF) && !if_flush;
    if_rsp_inst  = '0;
    if (if_rsp_valid) begin
      if_rsp_inst = pick_inst(mem_rdata, lane);
    end
    ls_rsp_valid = (owner == OWN_LS_RD) || (owner == OWN_LS_WR);
    ls_rsp_rdata = (owner == OWN_LS_RD) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios followed by random traffic against a reference model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned MAXS   = 4;

  logic              clk;
  logic              rst_n;
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_inst;
  logic              ls_req_valid;
  logic              ls_req_we;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [63:0]       ls_req_wdata;
  logic [7:0]        ls_req_be;
  logic              ls_req_ready;
  logic              ls_rsp_valid;
  logic [63:0]       ls_rsp_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-4:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_be;
  logic [63:0]       mem_rdata;

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (64),
    .INST_W       (32),
    .MAX_LS_STREAK(MAXS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_valid(if_req_valid),
    .if_req_addr (if_req_addr),
    .if_req_ready(if_req_ready),
    .if_flush    (if_flush),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_inst (if_rsp_inst),
    .ls_req_valid(ls_req_valid),
    .ls_req_we   (ls_req_we),
    .ls_req_addr (ls_req_addr),
    .ls_req_wdata(ls_req_wdata),
    .ls_req_be   (ls_req_be),
    .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid),
    .ls_rsp_rdata(ls_rsp_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM macro: synchronous read, byte-enabled write.
  bit [63:0] ram [1024];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Reference model state: memory contents as seen by completed requests.
  bit [63:0] gold [1024];
  int        ls_run;
  bit        exp_if_v, exp_ls_v;
  bit [31:0] exp_if_inst;
  bit [63:0] exp_ls_rdata;
  bit        last_if_gr, last_ls_gr;
  logic        obs_if_ready, obs_if_rsp_v;
  logic [31:0] obs_if_inst;
  logic [63:0] obs_ls_rdata;
  int n_tests, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_ready"}, if_req_ready, 0);
    chk({tag, "_ls_ready"}, ls_req_ready, 0);
    chk({tag, "_if_rsp_v"}, if_rsp_valid, 0);
    chk({tag, "_if_inst"}, if_rsp_inst, 0);
    chk({tag, "_ls_rsp_v"}, ls_rsp_valid, 0);
    chk({tag, "_ls_rdata"}, ls_rsp_rdata, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
  endtask

  // One clock cycle: entered just after a rising edge with inputs already set.
  task automatic step();
    bit        g_if, g_ls, if_due;
    bit [9:0]  w;
    #1;
    if_due       = exp_if_v && !if_flush;
    obs_if_rsp_v = if_rsp_valid;
    obs_if_inst  = if_rsp_inst;
    obs_ls_rdata = ls_rsp_rdata;
    obs_if_ready = if_req_ready;
    chk("if_rsp_valid", if_rsp_valid, if_due);
    chk("if_rsp_inst", if_rsp_inst, if_due ? exp_if_inst : 32'h0);
    chk("ls_rsp_valid", ls_rsp_valid, exp_ls_v);
    chk("ls_rsp_rdata", ls_rsp_rdata, exp_ls_rdata);

    g_ls = ls_req_valid && !(if_req_valid && ls_run == MAXS);
    g_if = if_req_valid && !g_ls;
    chk("if_req_ready", if_req_ready, g_if);
    chk("ls_req_ready", ls_req_ready, g_ls);
    chk("mem_en", mem_en, g_if || g_ls);
    chk("mem_we", mem_we, g_ls && ls_req_we);
    if (g_ls) begin
      chk("mem_addr_ls", mem_addr, ls_req_addr / 8);
      chk("mem_be_ls", mem_be, ls_req_we ? ls_req_be : 8'hFF);
      if (ls_req_we) chk("mem_wdata", mem_wdata, ls_req_wdata);
    end else if (g_if) begin
      chk("mem_addr_if", mem_addr, if_req_addr / 8);
      chk("mem_be_if", mem_be, 8'hFF);
    end

    exp_if_v     = g_if;
    exp_if_inst  = '0;
    exp_ls_v     = g_ls;
    exp_ls_rdata = '0;
    if (g_if) begin
      w = 10'(if_req_addr / 8);
      exp_if_inst = if_req_addr[2] ? gold[w][63:32] : gold[w][31:0];
    end
    if (g_ls) begin
      w = 10'(ls_req_addr / 8);
      if (ls_req_we) begin
        for (int b = 0; b < 8; b++)
          if (ls_req_be[b]) gold[w][b*8 +: 8] = ls_req_wdata[b*8 +: 8];
      end else begin
        exp_ls_rdata = gold[w];
      end
    end
    if (if_req_valid && !g_if) ls_run = (ls_run < MAXS) ? ls_run + 1 : MAXS;
    else ls_run = 0;
    last_if_gr = g_if;
    last_ls_gr = g_ls;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_pending();
    exp_if_v = 0; exp_ls_v = 0; exp_if_inst = '0; exp_ls_rdata = '0; ls_run = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    if_req_valid = 0; if_req_addr = '0; if_flush = 0;
    ls_req_valid = 0; ls_req_we = 0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_be = '0;
    drop_pending();
    #1;
    chk_zero("reset");
    chk("reset_streak", dut.u_grant.ls_streak, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) step();
    chk("idle_streak", dut.u_grant.ls_streak, 0);

    // Preload word 0 through the LS port.
    ls_req_valid = 1; ls_req_we = 1; ls_req_addr = 13'h000;
    ls_req_wdata = 64'h11112222_33334444; ls_req_be = 8'hFF;
    step();
    ls_req_valid = 0;

    // Fetch both instructions of word 0 in consecutive cycles.
    if_req_valid = 1; if_req_addr = 13'h000;
    step();
    chk("t1_valid0", if_rsp_valid, 1);
    chk("t1_inst0", if_rsp_inst, 32'h33334444);
    if_req_addr = 13'h004;
    step();
    chk("t1_inst1", if_rsp_inst, 32'h11112222);
    if_req_valid = 0;

    // Partial store then same-address load.
    ls_req_valid = 1; ls_req_we = 1; ls_req_addr = 13'h010;
    ls_req_wdata = 64'hDEADBEEF_CAFEF00D; ls_req_be = 8'h0F;
    step();
    chk("t2_st_ack", ls_rsp_valid, 1);
    chk("t2_st_data", ls_rsp_rdata, 0);
    ls_req_we = 0;
    step();
    chk("t2_ld_valid", ls_rsp_valid, 1);
    chk("t2_ld_data", ls_rsp_rdata, 64'h00000000_CAFEF00D);
    ls_req_valid = 0;
    step();

    // Continuous contention: LS x4 then IF, repeating.
    if_req_valid = 1; if_req_addr = 13'h000;
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 13'h010;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t3_if_grant", obs_if_ready, (i % 5) == 4);
    end
    if_req_valid = 0; ls_req_valid = 0;
    step();

    // Flush the due IF response while a new fetch is granted.
    if_req_valid = 1; if_req_addr = 13'h000;
    step();
    if_req_addr = 13'h004; if_flush = 1;
    step();
    chk("t4_flushed", obs_if_rsp_v, 0);
    if_flush = 0; if_req_valid = 0;
    step();
    chk("t4_after_v", obs_if_rsp_v, 1);
    chk("t4_after_inst", obs_if_inst, 32'h11112222);

    // Reset right after an LS read grant.
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 13'h000;
    step();
    rst_n = 1'b0;
    #1;
    chk_zero("t5_rst");
    drop_pending();
    @(posedge clk);
    #1;
    chk_zero("t5_hold");
    rst_n = 1'b1;
    step();
    ls_req_valid = 0;
    step();
    chk("t5_reload", obs_ls_rdata, 64'h11112222_33334444);

    // Random traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      if (!if_req_valid || last_if_gr) begin
        if_req_valid = ($urandom_range(0, 99) < 60);
        if_req_addr  = 13'(($urandom_range(0, 15) << 3) | ($urandom_range(0, 1) << 2));
      end
      if (!ls_req_valid || last_ls_gr) begin
        ls_req_valid = ($urandom_range(0, 99) < 60);
        ls_req_we    = $urandom_range(0, 1) == 1;
        ls_req_addr  = 13'($urandom_range(0, 15) << 3);
        ls_req_wdata = {$urandom, $urandom};
        ls_req_be    = 8'($urandom);
      end
      if_flush = ($urandom_range(0, 3) == 0);
      step();
    end
    if_req_valid = 0; ls_req_valid = 0; if_flush = 0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
